// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: default datapath widths, the NOP encoding
// and the IF/ID entry layout carried between fetch and decode.
package pipe_pkg;

    localparam int INSTR_W_DEFAULT = 16;
    localparam int PC_W_DEFAULT    = 16;

    localparam logic [15:0] NOP_INSTR = 16'h0800;

    typedef struct packed {
        logic [INSTR_W_DEFAULT-1:0] instr;
        logic [PC_W_DEFAULT-1:0]    pc_plus_two;
        logic                       err;
    } if_id_entry_t;

endpackage

// File: rtl/queue_ptr_ctrl.sv
// Pointer/occupancy control for a small in-order circular queue, with flush
// taking priority over any simultaneous push or pop.
module queue_ptr_ctrl #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     out_ready,
    input  logic                     flush,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic                     wr_en,
    output logic [$clog2(DEPTH)-1:0] wr_ptr,
    output logic [$clog2(DEPTH)-1:0] rd_ptr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             push;
    logic             pop;

    // Handshake flags depend only on the registered count, never on out_ready.
    assign in_ready  = (count_reg != FULL_CNT);
    assign out_valid = (count_reg != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign wr_en     = push & ~flush;

    assign wr_ptr = wr_ptr_reg;
    assign rd_ptr = rd_ptr_reg;
    assign count  = count_reg;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

endmodule

// File: rtl/if_id_queue.sv
// DEPTH-entry in-order queue between fetch and decode; decode sees NOP/0/0
// whenever no valid entry is presented.
module if_id_queue
    import pipe_pkg::*;
#(
    parameter int                 INSTR_W = INSTR_W_DEFAULT,
    parameter int                 PC_W    = PC_W_DEFAULT,
    parameter int                 DEPTH   = 2,
    parameter logic [INSTR_W-1:0] NOP     = INSTR_W'(NOP_INSTR)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_W-1:0]     instr_in,
    input  logic [PC_W-1:0]        pc_plus_two_in,
    input  logic                   err_in,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_W-1:0]     instr_out,
    output logic [PC_W-1:0]        pc_plus_two_out,
    output logic                   err_out,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    // Same field order as if_id_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc_plus_two;
        logic               err;
    } entry_t;

    logic             wr_en;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    entry_t           storage [DEPTH];
    entry_t           head;

    queue_ptr_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .flush     (flush),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .wr_en     (wr_en),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .count     (count)
    );

    // Storage is deliberately left out of reset and flush; occupancy gates it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            storage[wr_ptr] <= {instr_in, pc_plus_two_in, err_in};
        end
    end

    assign head = storage[rd_ptr];

    always_comb begin
        instr_out       = NOP;
        pc_plus_two_out = '0;
        err_out         = 1'b0;
        if (out_valid) begin
            instr_out       = head.instr;
            pc_plus_two_out = head.pc_plus_two;
            err_out         = head.err;
        end
    end

endmodule
